// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sweep driver: opcodes, FSM states and the
// mapping of a 10-bit vector index onto {op, A, B}.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam logic [9:0] LAST_IDX = 10'd1023;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CHECK,
        DONE
    } state_t;

    // Field order makes B the fastest-varying part of the index.
    typedef struct packed {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } vector_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 4-bit ALU; same ports as the ALU under test.
module alu_ref_model
    import alu_pkg::*;
(
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [1:0] op,
    output logic [3:0] Y,
    output logic       carry_out,
    output logic       zero_flag
);

    logic [4:0] result;

    always_comb begin
        // NOTE: assign a default before the case so no path leaves result unassigned (no latch).
        result = 5'd0;
        case (op)
            OP_ADD:  result = {1'b0, A} + {1'b0, B};
            OP_SUB:  result = {1'b0, A} - {1'b0, B};
            OP_AND:  result = {1'b0, A & B};
            default: result = {1'b0, A | B};
        endcase
    end

    assign {carry_out, Y} = result;
    assign zero_flag      = (Y == 4'd0);

endmodule

// File: rtl/alu_sweep_driver.sv
// Exhaustively drives all 1024 {op,A,B} vectors into an external ALU and
// compares each response against alu_ref_model, counting mismatches.
module alu_sweep_driver
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE       = 1,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  A,
    output logic [3:0]  B,
    output logic [1:0]  op,
    input  logic [3:0]  y_in,
    input  logic        carry_in,
    input  logic        zero_in,
    output logic        busy,
    output logic        done,
    output logic [10:0] mismatch_cnt,
    output logic        fail_valid,
    output logic [9:0]  first_fail_idx
);

    localparam logic [3:0] SETTLE_M1 = SETTLE[3:0] - 4'd1;

    state_t     state;
    logic [9:0] idx;
    logic [3:0] wait_cnt;
    vector_t    vec;

    logic [3:0] ref_y;
    logic       ref_carry;
    logic       ref_zero;
    logic       miss;

    alu_ref_model u_ref (
        .A         (vec.a),
        .B         (vec.b),
        .op        (vec.op),
        .Y         (ref_y),
        .carry_out (ref_carry),
        .zero_flag (ref_zero)
    );

    assign A    = vec.a;
    assign B    = vec.b;
    assign op   = vec.op;
    assign miss = ({y_in, carry_in, zero_in} != {ref_y, ref_carry, ref_zero});

    // NOTE: all state here is updated with <= so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            wait_cnt       <= '0;
            vec            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mismatch_cnt   <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= DRIVE;
                        idx            <= '0;
                        vec            <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        mismatch_cnt   <= '0;
                        fail_valid     <= 1'b0;
                        first_fail_idx <= '0;
                    end
                end
                DRIVE: begin
                    if (SETTLE == 0) begin
                        state <= CHECK;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= SETTLE_M1;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) state <= CHECK;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                CHECK: begin
                    if (miss) begin
                        mismatch_cnt <= mismatch_cnt + 11'd1;
                        if (!fail_valid) begin
                            fail_valid     <= 1'b1;
                            first_fail_idx <= idx;
                        end
                    end
                    if (idx == LAST_IDX || (miss && STOP_ON_FAIL)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        // Operands for the next vector appear together with DRIVE.
                        idx   <= idx + 10'd1;
                        vec   <= vector_t'(idx + 10'd1);
                        state <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Self-checking bench: several driver instances with different SETTLE/STOP_ON_FAIL,
// each wired to a behavioural ALU that can be corrupted on chosen vectors.
module tb_alu_sweep_driver;
    import alu_pkg::*;

    localparam int N = 4;

    function automatic int unsigned settle_of(input int k);
        case (k)
            0:       return 1;
            1:       return 1;
            2:       return 0;
            default: return 4;
        endcase
    endfunction

    function automatic bit stop_of(input int k);
        return (k == 1 || k == 3);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v   [N];
    logic        start_v [N];
    logic [3:0]  a_v     [N];
    logic [3:0]  b_v     [N];
    logic [1:0]  op_v    [N];
    logic [3:0]  y_v     [N];
    logic        carry_v [N];
    logic        zero_v  [N];
    logic        busy_v  [N];
    logic        done_v  [N];
    logic [10:0] cnt_v   [N];
    logic        fail_v  [N];
    logic [9:0]  first_v [N];

    // kind: 0 clean, 1 invert Y, 2 flip carry, 3 flip zero (on masked vectors), 4 carry stuck at 0
    int   kind_v     [N];
    logic fault_mask [N][1024];

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [5:0] bench_alu(input logic [1:0] o, input logic [3:0] a,
                                             input logic [3:0] b, input int kind, input logic hit);
        int r;
        logic [3:0] y;
        logic c, z;
        c = 1'b0;
        case (o)
            OP_ADD: begin r = int'(a) + int'(b); c = (r > 15); end
            OP_SUB: begin r = int'(a) - int'(b); c = (r < 0); end
            OP_AND: r = int'(a & b);
            default: r = int'(a | b);
        endcase
        y = 4'((r + 16) % 16);
        z = (y == 4'd0);
        if (kind == 4) c = 1'b0;
        else if (hit) begin
            case (kind)
                1: y = ~y;
                2: c = ~c;
                3: z = ~z;
                default: ;
            endcase
        end
        return {z, c, y};
    endfunction

    for (genvar k = 0; k < N; k++) begin : g_dut
        alu_sweep_driver #(
            .SETTLE       (settle_of(k)),
            .STOP_ON_FAIL (stop_of(k))
        ) u_dut (
            .clk            (clk),
            .rst            (rst_v[k]),
            .start          (start_v[k]),
            .A              (a_v[k]),
            .B              (b_v[k]),
            .op             (op_v[k]),
            .y_in           (y_v[k]),
            .carry_in       (carry_v[k]),
            .zero_in        (zero_v[k]),
            .busy           (busy_v[k]),
            .done           (done_v[k]),
            .mismatch_cnt   (cnt_v[k]),
            .fail_valid     (fail_v[k]),
            .first_fail_idx (first_v[k])
        );
        assign {zero_v[k], carry_v[k], y_v[k]} =
            bench_alu(op_v[k], a_v[k], b_v[k], kind_v[k], fault_mask[k][{op_v[k], a_v[k], b_v[k]}]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic clear_faults(input int k);
        for (int i = 0; i < 1024; i++) fault_mask[k][i] = 1'b0;
        kind_v[k] = 0;
    endtask

    // Failing vectors derived from the fault description, one vector at a time.
    task automatic model_expect(input int k, output int cnt, output int first);
        int o, a, b;
        bit bad;
        cnt = 0;
        first = -1;
        for (int i = 0; i < 1024; i++) begin
            o = i / 256;
            a = (i / 16) % 16;
            b = i % 16;
            if (kind_v[k] == 4) bad = (o == 0 && a + b > 15) || (o == 1 && a < b);
            else                bad = (kind_v[k] != 0) && fault_mask[k][i];
            if (bad) begin
                if (first < 0) first = i;
                cnt++;
            end
        end
    endtask

    task automatic check_reset(input int k, input string tag);
        check({tag, ".busy"},  32'(busy_v[k]), 0);
        check({tag, ".done"},  32'(done_v[k]), 0);
        check({tag, ".cnt"},   32'(cnt_v[k]), 0);
        check({tag, ".fail"},  32'(fail_v[k]), 0);
        check({tag, ".first"}, 32'(first_v[k]), 0);
        check({tag, ".vec"},   32'({op_v[k], a_v[k], b_v[k]}), 0);
    endtask

    // Starts a sweep and follows it until done; records each run of identical operands.
    task automatic run_sweep(input int k, input bit hold, output int cycles, output int runs,
                             output int bad);
        int cur, len, per, v;
        per = int'(settle_of(k)) + 2;
        @(negedge clk);
        start_v[k] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start_v[k] = 1'b0;
        cycles = 0; cur = -1; len = 0; runs = 0; bad = 0;
        forever begin
            if (busy_v[k]) begin
                v = int'({op_v[k], a_v[k], b_v[k]});
                if (v != cur) begin
                    if (cur >= 0 && len != per) bad++;
                    if (v != runs) bad++;
                    runs++;
                    cur = v;
                    len = 1;
                end else len++;
            end
            if (done_v[k]) begin
                if (cur >= 0 && len != per) bad++;
                break;
            end
            if (cycles >= 8000) break;
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic verify_sweep(input int k, input string tag);
        int cycles, runs, bad, exp_cnt, exp_first, exp_runs, per;
        bit stops;
        model_expect(k, exp_cnt, exp_first);
        run_sweep(k, 1'b0, cycles, runs, bad);
        per   = int'(settle_of(k)) + 2;
        stops = stop_of(k) && exp_cnt > 0;
        exp_runs = stops ? exp_first + 1 : 1024;
        if (stops) exp_cnt = 1;
        check({tag, ".cycles"}, cycles, exp_runs * per);
        check({tag, ".runs"},   runs, exp_runs);
        check({tag, ".timing"}, bad, 0);
        check({tag, ".cnt"},    32'(cnt_v[k]), exp_cnt);
        check({tag, ".fail"},   32'(fail_v[k]), (exp_cnt > 0) ? 1 : 0);
        check({tag, ".first"},  32'(first_v[k]), (exp_cnt > 0) ? exp_first : 0);
        check({tag, ".busy"},   32'(busy_v[k]), 0);
        check({tag, ".done"},   32'(done_v[k]), 1);
        if (stops) check({tag, ".vec"}, 32'({op_v[k], a_v[k], b_v[k]}), exp_first);
    endtask

    task automatic plant_random(input int k);
        int n;
        clear_faults(k);
        kind_v[k] = $urandom_range(3, 1);
        n = $urandom_range(6, 1);
        for (int j = 0; j < n; j++) fault_mask[k][$urandom_range(1023, 0)] = 1'b1;
    endtask

    initial begin
        int cycles, runs, bad;
        for (int k = 0; k < N; k++) begin
            rst_v[k]   = 1'b1;
            start_v[k] = 1'b0;
            clear_faults(k);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) check_reset(k, $sformatf("rst%0d", k));
        @(negedge clk);
        for (int k = 0; k < N; k++) rst_v[k] = 1'b0;

        verify_sweep(0, "clean");

        // A forced 4'hF equals the true sum 0xA+0x5, so the corruption inverts Y instead.
        fault_mask[0][10'h0A5] = 1'b1;
        kind_v[0] = 1;
        verify_sweep(0, "a5");
        clear_faults(0);

        fault_mask[1][10'h0A5] = 1'b1;
        kind_v[1] = 1;
        verify_sweep(1, "a5_stop");
        clear_faults(1);

        kind_v[0] = 4;
        verify_sweep(0, "carry0");
        check("carry0.total", 32'(cnt_v[0]), 240);
        clear_faults(0);

        for (int r = 0; r < 2; r++) begin
            plant_random(0);
            verify_sweep(0, $sformatf("rnd%0d.s1", r));
            plant_random(2);
            verify_sweep(2, $sformatf("rnd%0d.s0", r));
            plant_random(3);
            verify_sweep(3, $sformatf("rnd%0d.s4stop", r));
        end
        for (int k = 0; k < N; k++) clear_faults(k);

        // Abort mid-sweep with a partial result present; rst also wins over start.
        fault_mask[0][3] = 1'b1;
        kind_v[0] = 1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (499) @(negedge clk);
        check("abort.partial", 32'(cnt_v[0]), 1);
        rst_v[0]   = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        check_reset(0, "abort");
        @(negedge clk);
        rst_v[0]   = 1'b0;
        start_v[0] = 1'b0;
        clear_faults(0);
        repeat (3) @(negedge clk);
        check("abort.idle", 32'({busy_v[0], done_v[0]}), 0);
        verify_sweep(0, "after_abort");

        // Held start: no restart while busy, new sweep on the edge after DONE.
        run_sweep(0, 1'b1, cycles, runs, bad);
        check("hold.cycles", cycles, 3072);
        check("hold.runs", runs, 1024);
        check("hold.timing", bad, 0);
        @(posedge clk);
        #1;
        check("hold.restart_busy", 32'(busy_v[0]), 1);
        check("hold.restart_done", 32'(done_v[0]), 0);
        check("hold.restart_vec", 32'({op_v[0], a_v[0], b_v[0]}), 0);
        @(negedge clk);
        start_v[0] = 1'b0;
        rst_v[0]   = 1'b1;
        @(negedge clk);
        rst_v[0]   = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
